mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised successor to the CPU's single-requester memory path. It arbitrates NUM_PORTS pipeline
//  requesters (port 0 = IF fetch, port 1 = MEM stage, extra ports for DMA/debug) onto one asynchronous
//  SRAM and the memory-mapped UART. It runs a timed SRAM/UART access FSM and returns per-port ready/
//  response pulses, plus a stall level that the hazard logic uses to freeze PC and pipeline registers.
// PARAMETERS
//  NUM_PORTS   2        number of requesters, 1..8
//  ADDR_W      18       SRAM address width; request addresses are zero-extended from 16 bits
//  DATA_W      16       data width
//  WAIT_CYCLES 1        SRAM access cycles, 1..15; OE/WE low for this many cycles
//  UART_DATA   16'hBF00 UART data address
//  UART_STAT   16'hBF01 UART status address
// PORTS
//  CLK        in    1                  clock, all state changes on rising edge
//  RST        in    1                  reset, synchronous, active-low
//  req_valid  in    NUM_PORTS          request pending; held with its fields until req_ready
//  req_write  in    NUM_PORTS          1 = write, 0 = read
//  req_addr   in    NUM_PORTS*16       word address, port p at [16p+15:16p]
//  req_wdata  in    NUM_PORTS*DATA_W   write data
//  req_ready  out   NUM_PORTS          one-cycle completion pulse to the granted port
//  resp_rdata out   NUM_PORTS*DATA_W   read data, valid while req_ready[p]=1 and the request is a read
//  stall      out   1                  |(req_valid & ~req_ready)
//  ramEN/ramOE/ramWE out 1             SRAM strobes, active-low
//  ramAddr    out   ADDR_W             SRAM address
//  ramData    inout DATA_W             shared SRAM/UART data bus
//  rdn, wrn   out   1                  UART strobes, active-low
//  data_ready, tbre, tsre in 1         UART status inputs
// BEHAVIOUR
//  Reset (RST=0 at edge): state IDLE; ramEN/OE/WE=1; rdn=wrn=1; ramData=Z; ramAddr=0;
//   req_ready=0; resp_rdata=0; rr_ptr=0. A reset mid-access aborts it and gives no ready pulse.
//  IDLE: if any req_valid, grant the first valid port scanning rr_ptr, rr_ptr+1, ... (mod NUM_PORTS);
//   latch the request fields; rr_ptr <= grant+1 mod N. Decode target: ==UART_DATA, ==UART_STAT, else SRAM.
//  SRAM read: SETUP (ramAddr driven, EN=0) -> ACCESS x WAIT_CYCLES (OE=0), sample on the last cycle
//   -> DONE (OE=1, req_ready pulse, resp_rdata valid). Latency = WAIT_CYCLES+2 cycles from the grant edge.
//  SRAM write: SETUP (addr+data driven, EN=0, WE=1) -> ACCESS x WAIT_CYCLES (WE=0) -> DONE (WE=1;
//   addr/data still driven as hold; ready pulse). EN returns to 1 in IDLE.
//  UART_STAT read: 1 cycle after grant, ready with data {zeros, data_ready, tbre&tsre} in bits [1:0].
//  UART_DATA read: rdn=0 for 2 cycles, sample ramData[7:0] on 2nd, [15:8]=0; rdn=1; ready.
//   Does not wait on data_ready; software polls UART_STAT first.
//  UART_DATA write: drive low byte, wrn=0 for 1 cycle, wrn=1; WAIT_TBRE until tbre=1, then
//   WAIT_TSRE until tsre=1; then ready. No timeout.
//  ramData is driven only in write states; it is Z in all others. SRAM and UART strobes are never
//   active together.
//  A port whose request completes may re-request next cycle. There is always one IDLE cycle between
//   accesses, so back-to-back requests from two ports alternate (no starvation).
//  Write requests produce no meaningful resp_rdata; they hold the previous value.
// STRUCTURE
//  Package mem_pkg: state enum (IDLE, SETUP, ACCESS, DONE, U_RD, U_WR, WAIT_TBRE, WAIT_TSRE),
//   UART address constants, target-decode function.
//  Sub-module rr_arbiter (NUM_PORTS): req vector + rr_ptr -> one-hot grant and index.
//  Top: FSM, wait counter (4 bits), request latch, bus drivers.
// TESTING
//  1. N=2, W=1; port0 read 0x0010 (SRAM=0x1234) -> OE low 1 cycle, ready0 at grant+3, rdata=0x1234.
//  2. Both ports valid in the same cycle from reset -> port0 served first, then port1; repeat -> ordering alternates.
//  3. Port1 write 0x0020=0xBEEF, W=3 -> WE low exactly 3 cycles, data held 1 cycle after; readback=0xBEEF.
//  4. Write 0x0041 to UART_DATA -> wrn 1-cycle pulse with ramData[7:0]=0x41; ready only after tbre then tsre rise.
//  5. Read UART_STAT with data_ready=1, tbre=tsre=1 -> rdata=0x0003 one cycle after grant; no strobes.
//  6. Assert RST=0 during ACCESS -> next edge all strobes=1, ramData=Z, no ready; stall follows req_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state/target types and UART address decode for the multi-port memory arbiter.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, DONE, U_RD, U_WR, WAIT_TBRE, WAIT_TSRE
  } state_t;

  typedef enum logic [1:0] {
    TGT_SRAM, TGT_UDATA, TGT_USTAT
  } target_t;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
  localparam int          REQ_ADDR_W     = 16;

  function automatic target_t decode_target(input logic [15:0] addr,
                                            input logic [15:0] data_addr,
                                            input logic [15:0] stat_addr);
    if (addr == data_addr) return TGT_UDATA;
    if (addr == stat_addr) return TGT_USTAT;
    return TGT_SRAM;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle: per-port request fields, completion pulses and stall.
interface mem_port_arbiter_if
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*REQ_ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0]     req_wdata;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS*DATA_W-1:0]     resp_rdata;
  logic                            stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_rdata, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_rdata, stall
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request scanning upward from ptr, wrapping modulo NUM_PORTS.
module rr_arbiter #(
  parameter int  NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one async SRAM and the memory-mapped UART,
// sequencing strobes with a timed FSM and returning a one-cycle ready per completed access.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          ADDR_W      = 18,
  parameter int          DATA_W      = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] UART_DATA   = UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT   = UART_STAT_ADDR
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.slave  bus,
  output logic               ramEN,
  output logic               ramOE,
  output logic               ramWE,
  output logic [ADDR_W-1:0]  ramAddr,
  inout  wire  [DATA_W-1:0]  ramData,
  output logic               rdn,
  output logic               wrn,
  input  logic               data_ready,
  input  logic               tbre,
  input  logic               tsre
);
  localparam int         IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        rr_ptr, gnt_idx, lat_idx;
  logic [NUM_PORTS-1:0]    gnt_vec, ready_vec;
  logic [3:0]              wait_cnt;
  logic [REQ_ADDR_W-1:0]   gnt_addr;
  target_t                 gnt_tgt, lat_tgt;
  logic                    grant, gnt_write, lat_write;
  logic [DATA_W-1:0]       gnt_wdata, lat_wdata, rdata_q, drive_val;
  logic [ADDR_W-1:0]       addr_q;
  logic                    drive_en;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_vec),
    .idx   (gnt_idx)
  );

  assign grant     = |gnt_vec;
  assign gnt_addr  = bus.req_addr[int'(gnt_idx)*REQ_ADDR_W +: REQ_ADDR_W];
  assign gnt_wdata = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign gnt_write = bus.req_write[gnt_idx];
  assign gnt_tgt   = decode_target(gnt_addr, UART_DATA, UART_STAT);

  // Strobes and bus drive are decoded from registered state only, so they never glitch on request changes.
  always_comb begin
    state_n   = state;
    ramEN     = 1'b1;
    ramOE     = 1'b1;
    ramWE     = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    drive_en  = 1'b0;
    drive_val = lat_wdata;
    case (state)
      IDLE: begin
        if (grant) begin
          case (gnt_tgt)
            TGT_SRAM:  state_n = SETUP;
            TGT_USTAT: state_n = DONE;
            default:   state_n = gnt_write ? U_WR : U_RD;
          endcase
        end
      end
      SETUP: begin
        ramEN    = 1'b0;
        drive_en = lat_write;
        state_n  = ACCESS;
      end
      ACCESS: begin
        ramEN    = 1'b0;
        ramOE    = lat_write;
        ramWE    = !lat_write;
        drive_en = lat_write;
        if (wait_cnt == LAST_WAIT) state_n = DONE;
      end
      DONE: begin
        // SRAM keeps EN and write data one extra cycle as hold time after WE rises.
        if (lat_tgt == TGT_SRAM) begin
          ramEN    = 1'b0;
          drive_en = lat_write;
        end
        state_n = IDLE;
      end
      U_RD: begin
        rdn = 1'b0;
        if (wait_cnt == 4'd1) state_n = DONE;
      end
      U_WR: begin
        wrn       = 1'b0;
        drive_en  = 1'b1;
        drive_val = DATA_W'(lat_wdata[7:0]);
        state_n   = WAIT_TBRE;
      end
      WAIT_TBRE: if (tbre) state_n = WAIT_TSRE;
      WAIT_TSRE: if (tsre) state_n = DONE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (grant) begin
            rr_ptr   <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
            wait_cnt <= '0;
            if (gnt_tgt == TGT_SRAM) addr_q <= ADDR_W'(gnt_addr);
            if (gnt_tgt == TGT_USTAT && !gnt_write)
              rdata_q <= DATA_W'({data_ready, tbre & tsre});
          end
        end
        ACCESS: begin
          if (wait_cnt == LAST_WAIT) begin
            if (!lat_write) rdata_q <= ramData;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        U_RD: begin
          if (wait_cnt == 4'd1) rdata_q <= DATA_W'(ramData[7:0]);
          else                  wait_cnt <= wait_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Request latch: only consulted outside IDLE, and state itself is reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (state == IDLE && grant) begin
      lat_idx   <= gnt_idx;
      lat_write <= gnt_write;
      lat_wdata <= gnt_wdata;
      lat_tgt   <= gnt_tgt;
    end
  end

  always_comb begin
    ready_vec = '0;
    if (state == DONE) ready_vec[lat_idx] = 1'b1;
  end

  assign bus.req_ready  = ready_vec;
  assign bus.resp_rdata = {NUM_PORTS{rdata_q}};
  assign bus.stall      = |(bus.req_valid & ~ready_vec);
  assign ramAddr        = addr_q;
  assign ramData        = drive_en ? drive_val : {DATA_W{1'bz}};
endmodule
